// File: rtl/mux_serializer.sv
// Word-to-bitstream serializer that drives an external 32:1 mux.
// Latches a word, walks the mux select and emits one bit per valid/ready beat.
module mux_serializer #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  logic [31:0] in_data_i,
    input  logic [5:0]  in_len_i,
    output logic [31:0] mux_data_o,
    output logic [4:0]  mux_sel_o,
    input  logic        mux_out_i,
    output logic        ser_valid_o,
    input  logic        ser_ready_i,
    output logic        ser_bit_o,
    output logic        ser_last_o,
    output logic        busy_o
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [4:0] IDX0 = MSB_FIRST ? 5'd31 : 5'd0;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [31:0] r_data;
    logic [4:0]  r_idx;
    logic [5:0]  r_rem;
    logic        r_bit;
    logic        r_valid;
    logic        r_last;

    logic        w_idle;
    logic        w_run;
    logic        w_accept;
    logic        w_load;
    logic        w_hs;
    logic        w_done;
    logic [5:0]  w_len;

    assign w_idle   = (r_state == S_IDLE);
    assign w_run    = (r_state == S_RUN);
    assign w_accept = w_idle & in_valid_i & ~rst_i;
    assign w_hs     = r_valid & ser_ready_i;
    assign w_done   = w_run & w_hs & r_last;
    assign w_load   = w_run & (r_rem != 6'd0) & (~r_valid | ser_ready_i);

    // Zero and oversize lengths both mean a full 32-bit word.
    assign w_len = ((in_len_i == 6'd0) || (in_len_i > 6'd32)) ? 6'd32 : in_len_i;

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state: leave RUN only on the handshake of the final bit.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_RUN;
            S_RUN:   if (w_done)   w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state; ready is masked during reset.
    always_comb begin
        in_ready_o = w_idle & ~rst_i;
        busy_o     = w_run;
    end

    // Datapath: word latch, index walk and the registered serial stage.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_data  <= 32'd0;
            r_idx   <= IDX0;
            r_rem   <= 6'd0;
            r_bit   <= 1'b0;
            r_valid <= 1'b0;
            r_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_data <= in_data_i;
                r_rem  <= w_len;
                r_idx  <= IDX0;
            end
            if (w_load) begin
                r_bit   <= mux_out_i;
                r_valid <= 1'b1;
                r_last  <= (r_rem == 6'd1);
                r_rem   <= r_rem - 6'd1;
                // The final step is skipped so the index never wraps.
                if (r_rem != 6'd1) begin
                    r_idx <= MSB_FIRST ? r_idx - 5'd1 : r_idx + 5'd1;
                end
            end else if (w_hs) begin
                r_valid <= 1'b0;
                r_last  <= 1'b0;
            end
        end
    end

    assign mux_data_o  = r_data;
    assign mux_sel_o   = r_idx;
    assign ser_valid_o = r_valid;
    assign ser_bit_o   = r_bit;
    assign ser_last_o  = r_last;

endmodule
